demux1_8_buf: RTL and testbench

Buffered 1-to-8 demultiplexer: the distribution end of the ALU's 8:1 32-bit result-select path. It accepts one 32-bit word per cycle with a 3-bit destination select and steers it into one of eight lane holding registers. Each lane presents the word with a valid flag until its consumer acknowledges it. Backpressure is per lane, and an occupancy counter reports how many lanes hold data.

---
 rtl/demux_pkg.sv | 24 ++
 rtl/demux1_8_lane.sv | 46 ++++
 rtl/demux1_8_buf.sv | 81 ++++++++
 tb/tb_demux1_8_buf.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants, lane state type and popcount helper for demux1_8_buf.
package demux_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int LANES     = 8;
  localparam int SEL_W     = 3;
  localparam int CNT_W     = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_e;

  function automatic logic [CNT_W-1:0] popcnt(
    input logic [LANES-1:0] v
  );
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++)
      c = c + CNT_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/demux1_8_lane.sv
// One output lane: holding register, valid flag and lane-level ready.
module demux1_8_lane
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic             ack,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             rdy
);

  lane_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = FULL;
      data_d  = d;
    end else if (clear) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign q     = data_q;
  assign valid = (state_q == FULL);
  assign rdy   = (state_q == EMPTY) | ack;

endmodule

// File: rtl/demux1_8_buf.sv
// Buffered 1-to-8 demux with per-lane backpressure and occupancy count.
// Optional broadcast port enabled by defining DEMUX_BCAST_EN.
module demux1_8_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       s,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_valid,
  input  logic [LANES-1:0]       out_ack,
`ifdef DEMUX_BCAST_EN
  input  logic                   bcast,
`endif
  output logic [CNT_W-1:0]       count
);

  logic [LANES-1:0] sel_oh;
  logic [LANES-1:0] lane_rdy;
  logic [LANES-1:0] load;
  logic [LANES-1:0] clear;
  logic [CNT_W-1:0] count_q, count_d;

  // Gating on in_valid keeps an unknown s away from lane state.
  always_comb begin
    sel_oh = '0;
    if (in_valid)
      sel_oh[s] = 1'b1;
  end

`ifdef DEMUX_BCAST_EN
  always_comb begin
    in_ready = bcast ? (&lane_rdy) : lane_rdy[s];
    load     = '0;
    if (in_valid & in_ready)
      load = bcast ? {LANES{1'b1}} : sel_oh;
  end
`else
  always_comb begin
    in_ready = lane_rdy[s];
    load     = sel_oh & {LANES{in_ready}};
  end
`endif

  assign clear = out_ack & out_valid & ~load;

  always_comb begin
    count_d = count_q
            + popcnt(load & ~out_valid)
            - popcnt(clear);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count = count_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    demux1_8_lane #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .load  (load[k]),
      .clear (clear[k]),
      .ack   (out_ack[k]),
      .d     (in_data),
      .q     (out_data[k*WIDTH +: WIDTH]),
      .valid (out_valid[k]),
      .rdy   (lane_rdy[k])
    );
  end

endmodule

// File: tb/tb_demux1_8_buf.sv
// Self-checking bench for demux1_8_buf: directed steps plus random traffic
// against a lane-array reference model.
module tb_demux1_8_buf;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  in_data;
  logic [2:0]   s;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] out_data;
  logic [7:0]   out_valid;
  logic [7:0]   out_ack;
  logic [3:0]   count;
`ifdef DEMUX_BCAST_EN
  logic         bcast;
`endif

  int checks = 0;
  int failures = 0;

  bit          mv[8];
  logic [31:0] md[8];

  always #5 clk = ~clk;

  demux1_8_buf dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .s         (s),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ack   (out_ack),
`ifdef DEMUX_BCAST_EN
    .bcast     (bcast),
`endif
    .count     (count)
  );

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_valid();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = mv[k];
    return v;
  endfunction

  function automatic logic [255:0] m_data();
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = md[k];
    return d;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int k = 0; k < 8; k++) c += mv[k];
    return c;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 8; k++) begin
      mv[k] = 0;
      md[k] = '0;
    end
  endtask

  function automatic bit m_ready(input logic [2:0] sel,
                                 input logic [7:0] ack,
                                 input bit bc);
    bit r;
    if (bc) begin
      r = 1;
      for (int k = 0; k < 8; k++)
        if (mv[k] && !ack[k]) r = 0;
    end else begin
      r = !mv[sel] || ack[sel];
    end
    return r;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".valid"}, 256'(out_valid), 256'(m_valid()));
    chk({tag, ".count"}, 256'(count), 256'(m_count()));
    chk({tag, ".data"}, out_data, m_data());
  endtask

  // Called just after a negedge; returns just after the next negedge.
  task automatic step(input bit v, input logic [2:0] sel,
                      input logic [31:0] d, input logic [7:0] ack,
                      input bit bc, input bit full_chk);
    bit rdy;
    in_valid = v;
    s        = v ? sel : 3'bxxx;
    in_data  = d;
    out_ack  = ack;
`ifdef DEMUX_BCAST_EN
    bcast    = bc;
`endif
    rdy = m_ready(sel, ack, bc);
    #1;
    if (v) chk("in_ready", 256'(in_ready), 256'(rdy));
    @(posedge clk);
    for (int k = 0; k < 8; k++)
      if (ack[k]) mv[k] = 0;
    if (v && rdy) begin
      for (int k = 0; k < 8; k++)
        if (bc || k == int'(sel)) begin
          mv[k] = 1;
          md[k] = d;
        end
    end
    #1;
    if (full_chk) check_state("step");
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'(($urandom));
    s        = 3'($urandom);
    in_data  = $urandom;
    out_ack  = 8'($urandom);
`ifdef DEMUX_BCAST_EN
    bcast    = 1'b0;
`endif
    m_reset();
    @(negedge clk);
    check_state("reset");
    for (int i = 0; i < 8; i++) begin
      s = 3'(i);
      #1;
      chk("reset.in_ready", 256'(in_ready), 256'(1));
    end
    @(negedge clk);
    rst = 1'b0;

    // single unicast word to lane 5
    step(1, 3'd5, 32'hDEADBEEF, 8'h00, 0, 1);
    chk("lane5.valid", 256'(out_valid), 256'(8'b0010_0000));
    chk("lane5.data", 256'(out_data[5*32 +: 32]), 256'(32'hDEADBEEF));
    chk("lane5.count", 256'(count), 256'(1));

    // stall on full lane 5, then refill under ack
    for (int i = 0; i < 3; i++)
      step(1, 3'd5, 32'h1234_5678, 8'h00, 0, 1);
    chk("stall.data", 256'(out_data[5*32 +: 32]), 256'(32'hDEADBEEF));
    step(1, 3'd5, 32'h1234_5678, 8'h20, 0, 1);
    chk("refill.valid", 256'(out_valid), 256'(8'b0010_0000));
    chk("refill.count", 256'(count), 256'(1));
    chk("refill.data", 256'(out_data[5*32 +: 32]), 256'(32'h1234_5678));

    // drain, fill all lanes, multi-ack
    step(0, 3'd0, 32'h0, 8'hFF, 0, 1);
    for (int i = 0; i < 8; i++)
      step(1, 3'(i), 32'(i), 8'h00, 0, 1);
    chk("fill.count", 256'(count), 256'(8));
    step(0, 3'd0, 32'h0, 8'b1000_1001, 0, 1);
    chk("multiack.count", 256'(count), 256'(5));
    chk("multiack.valid", 256'(out_valid), 256'(8'b0111_0110));

    // async reset mid-cycle with 4 lanes full
    step(0, 3'd0, 32'h0, 8'hFF, 0, 1);
    for (int i = 0; i < 4; i++)
      step(1, 3'(2 * i), 32'hA000_0000 + 32'(i), 8'h00, 0, 1);
    chk("pre_rst.count", 256'(count), 256'(4));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.valid", 256'(out_valid), 256'(0));
    chk("async_rst.count", 256'(count), 256'(0));
    chk("async_rst.data", out_data, 256'(0));
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1, 3'd3, 32'hCAFE_0003, 8'h00, 0, 1);
    chk("post_rst.valid", 256'(out_valid), 256'(8'b0000_1000));

`ifdef DEMUX_BCAST_EN
    step(0, 3'd0, 32'h0, 8'hFF, 0, 1);
    step(1, 3'($urandom), 32'h0000_00A5, 8'h00, 1, 1);
    chk("bcast.count", 256'(count), 256'(8));
    chk("bcast.data", out_data, {8{32'h0000_00A5}});
    step(0, 3'd0, 32'h0, 8'b1111_1011, 0, 1);
    in_valid = 1'b1;
    bcast    = 1'b1;
    in_data  = 32'h5A;
    out_ack  = 8'h00;
    #1;
    chk("bcast.blocked", 256'(in_ready), 256'(0));
    @(negedge clk);
`endif

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit       v;
      bit       bc;
      logic [7:0] a;
      v  = ($urandom % 4) != 0;
      a  = 8'($urandom & $urandom & $urandom);
      bc = 0;
`ifdef DEMUX_BCAST_EN
      bc = ($urandom % 16) == 0;
`endif
      step(v, 3'($urandom), $urandom, a, bc, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
